// File: rtl/rand_pick_requester_pkg.sv
// GameControl shared definitions for the random tile picker: FSM state
// encodings, LFSR geometry/seed and the modulo-unit request bundle.
package rand_pick_requester_pkg;

    // LFSR geometry: 7-bit Fibonacci, x^7 + x^6 + 1 (maximal, period 127).
    localparam int                LFSR_W        = 7;
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 7'h60;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 7'h5A;

    // Requester FSM encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Operands handed to the shared modulo unit.
    typedef struct packed {
        logic [6:0] a;
        logic [6:0] b;
    } mod_req_t;

    // One Fibonacci step: shift toward the MSB, feed back the tap parity.
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rand_pick_requester_lfsr7.sv
// Free-running 7-bit LFSR with a synchronous seed load.
// Ports: clk; load_i (reload seed); state_o (current LFSR value).
module rand_pick_requester_lfsr7
    import rand_pick_requester_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              load_i,
    output logic [LFSR_W-1:0] state_o
);

    // An all-zero seed would lock the LFSR; fall back to the default.
    localparam logic [LFSR_W-1:0] SEED_SAFE =
        (SEED == '0) ? LFSR_SEED_DEF : SEED;

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    assign state_d = lfsr_next(state_q);

    always_ff @(posedge clk) begin
        if (load_i) begin
            state_q <= SEED_SAFE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/rand_pick_requester.sv
// Random tile-index picker: draws an LFSR value, has the shared modulo
// unit reduce it by the deck count and returns an index in [0, deck_cnt-1].
// Ports: clk, rst / interboard_rst (sync, active-high, same effect);
//   req, deck_cnt (pick request); busy, pick_valid, pick_idx, pick_err
//   (result side); mod_a, mod_b, mod_start, mod_ready, mod_done, mod_ans
//   (modulo-unit handshake).
// Optional: define RAND_TIMEOUT_EN for a TIMEOUT_CYCLES watchdog in WAIT.
module rand_pick_requester
    import rand_pick_requester_pkg::*;
#(
    parameter logic [6:0] LFSR_SEED      = LFSR_SEED_DEF,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       req,
    input  logic [6:0] deck_cnt,
    output logic       busy,
    output logic       pick_valid,
    output logic [6:0] pick_idx,
    output logic       pick_err,
    output logic [6:0] mod_a,
    output logic [6:0] mod_b,
    output logic       mod_start,
    input  logic       mod_ready,
    input  logic       mod_done,
    input  logic [6:0] mod_ans
);

    logic       reset_w;
    logic [6:0] lfsr_w;

    logic [1:0] state_q, state_d;
    mod_req_t   op_q, op_d;
    logic [6:0] idx_q, idx_d;
    logic       start_q, start_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    assign reset_w = rst | interboard_rst;

    rand_pick_requester_lfsr7 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .load_i  (reset_w),
        .state_o (lfsr_w)
    );

`ifdef RAND_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Counts WAIT cycles already spent; cleared on entry to WAIT.
    logic [7:0] tmo_q, tmo_d;
`else
    // Keeps the parameter referenced in builds without the watchdog.
    logic unused_tmo;
    assign unused_tmo = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;
`ifdef RAND_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (deck_cnt != 7'd0) begin
                        op_d.a  = lfsr_w;
                        op_d.b  = deck_cnt;
                        state_d = ST_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // Start is a registered pulse; leave only after it was seen.
                if (start_q) begin
                    state_d = ST_WAIT;
`ifdef RAND_TIMEOUT_EN
                    tmo_d   = 8'd0;
`endif
                end else if (mod_ready) begin
                    start_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mod_done) begin
                    idx_d   = mod_ans;
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end
`ifdef RAND_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_w) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

`ifdef RAND_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset_w) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign busy       = (state_q != ST_IDLE);
    assign pick_valid = valid_q;
    assign pick_idx   = idx_q;
    assign pick_err   = err_q;
    assign mod_a      = op_q.a;
    assign mod_b      = op_q.b;
    assign mod_start  = start_q;

endmodule

// File: tb/tb_rand_pick_requester.sv
// Bench for rand_pick_requester: table vectors, hand sequences and
// random picks checked against an LFSR-sequence / modulo reference.
module tb_rand_pick_requester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       interboard_rst = 1'b0;
    logic       req = 1'b0;
    logic [6:0] deck_cnt = 7'd0;
    logic       mod_ready = 1'b1;
    logic       mod_done = 1'b0;
    logic [6:0] mod_ans = 7'd0;
    logic       busy, pick_valid, pick_err, mod_start;
    logic [6:0] pick_idx, mod_a, mod_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rand_pick_requester #(
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .req            (req),
        .deck_cnt       (deck_cnt),
        .busy           (busy),
        .pick_valid     (pick_valid),
        .pick_idx       (pick_idx),
        .pick_err       (pick_err),
        .mod_a          (mod_a),
        .mod_b          (mod_b),
        .mod_start      (mod_start),
        .mod_ready      (mod_ready),
        .mod_done       (mod_done),
        .mod_ans        (mod_ans)
    );

    // Reference: the whole maximal-length sequence from the seed, indexed
    // by clock edges since the last reset.
    logic [6:0] seq [127];
    int ncyc = 0;

    always @(posedge clk) begin
        if (rst || interboard_rst) ncyc <= 0;
        else                       ncyc <= ncyc + 1;
    end

    function automatic int lfsr_at(input int k);
        return int'(seq[k % 127]);
    endfunction

    // Behavioural modulo unit: answers a start after resp_lat cycles.
    int         resp_lat = 1;
    bit         resp_en = 1'b1;
    int         stray_req = 0;
    int         stray_seen = 0;
    int         due = 0;
    logic [6:0] ra = 7'd0;

    always @(negedge clk) begin
        mod_done = 1'b0;
        if (stray_req != stray_seen) begin
            stray_seen = stray_req;
            mod_done   = 1'b1;
            mod_ans    = 7'h55;
        end
        if (due > 0) begin
            due = due - 1;
            if (due == 0) begin
                mod_done = 1'b1;
                mod_ans  = ra;
            end
        end
        if (mod_start === 1'b1 && resp_en && mod_b != 7'd0) begin
            ra  = mod_a % mod_b;
            due = resp_lat;
        end
    end

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    task automatic wait_idle(input string nm);
        int t = 0;
        while (busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk({nm, ":idle"}, int'(busy), 0);
    endtask

    task automatic do_pick(input logic [6:0] deck, input int stall,
                           input int lat, input int target,
                           input int exp_idx, input bit noise,
                           input string nm);
        int  t, starts, start_at, exp_a, exp_i;
        bit  done;
        wait_idle(nm);
        if (target >= 0) begin
            t = 0;
            while (lfsr_at(ncyc) != target && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk({nm, ":lfsr_hit"}, lfsr_at(ncyc), target);
        end
        resp_lat  = lat;
        resp_en   = 1'b1;
        mod_ready = (stall == 0);
        exp_a     = lfsr_at(ncyc);
        req       = 1'b1;
        deck_cnt  = deck;
        @(negedge clk);
        if (noise && deck != 7'd0) deck_cnt = 7'd5;
        else                       req = 1'b0;
        if (deck == 7'd0) begin
            chk({nm, ":err"}, int'(pick_err), 1);
            chk({nm, ":err_busy"}, int'(busy), 0);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                chk({nm, ":err_start"}, int'(mod_start), 0);
                chk({nm, ":err_busy2"}, int'(busy), 0);
                chk({nm, ":err_pulse"}, int'(pick_err), 0);
            end
            mod_ready = 1'b1;
            return;
        end
        chk({nm, ":mod_a"}, int'(mod_a), exp_a);
        chk({nm, ":mod_b"}, int'(mod_b), int'(deck));
        chk({nm, ":busy1"}, int'(busy), 1);
        exp_i    = (exp_idx >= 0) ? exp_idx : exp_a % int'(deck);
        starts   = 0;
        start_at = -1;
        done     = 1'b0;
        for (int k = 1; k < 60 && !done; k++) begin
            if (stall > 0 && k == stall + 1) mod_ready = 1'b1;
            if (noise && stall > 0 && k == 1) stray_req++;
            if (mod_start) begin
                starts++;
                if (start_at < 0) start_at = k;
            end
            if (pick_valid) begin
                done = 1'b1;
                req  = 1'b0;
                chk({nm, ":idx"}, int'(pick_idx), exp_i);
                chk({nm, ":latency"}, k, 3 + stall + lat);
                chk({nm, ":start_at"}, start_at, 2 + stall);
                chk({nm, ":starts"}, starts, 1);
                chk({nm, ":busy_done"}, int'(busy), 1);
                chk({nm, ":ab_stable"}, int'({mod_a, mod_b}),
                    int'({exp_a[6:0], deck}));
            end else begin
                if (!busy) chk({nm, ":busy_drop"}, int'(busy), 1);
                @(negedge clk);
            end
        end
        req = 1'b0;
        chk({nm, ":completed"}, int'(done), 1);
        @(negedge clk);
        chk({nm, ":valid_1cyc"}, int'(pick_valid), 0);
        chk({nm, ":busy_after"}, int'(busy), 0);
        chk({nm, ":idx_held"}, int'(pick_idx), exp_i);
        @(negedge clk);
        chk({nm, ":not_queued"}, int'(busy), 0);
    endtask

    typedef struct {
        logic [6:0] deck;
        int         stall;
        int         lat;
        int         target;
        int         exp_idx;
        bit         noise;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int         t, cnt;
        logic [6:0] old_idx;
        logic [6:0] rdeck;

        seq[0] = 7'h5A;
        for (int i = 1; i < 127; i++)
            seq[i] = {seq[i-1][5:0], seq[i-1][6] ^ seq[i-1][5]};

        vecs[0] = '{7'd127, 0, 2, -1,  90, 1'b0};
        vecs[1] = '{7'd13,  0, 2, 100,  9, 1'b0};
        vecs[2] = '{7'd1,   0, 1, -1,   0, 1'b0};
        vecs[3] = '{7'd0,   0, 1, -1,  -1, 1'b0};
        vecs[4] = '{7'd20,  5, 3, -1,  -1, 1'b1};
        vecs[5] = '{7'd127, 0, 4, -1,  -1, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(pick_valid), 0);
        chk("rst_err", int'(pick_err), 0);
        chk("rst_start", int'(mod_start), 0);
        chk("rst_idx", int'(pick_idx), 0);
        chk("rst_mod_a", int'(mod_a), 0);
        chk("rst_mod_b", int'(mod_b), 0);
        rst = 1'b0;

        foreach (vecs[i])
            do_pick(vecs[i].deck, vecs[i].stall, vecs[i].lat,
                    vecs[i].target, vecs[i].exp_idx, vecs[i].noise,
                    $sformatf("vec%0d", i));

        // Stray mod_done while idle is ignored.
        wait_idle("stray");
        stray_req++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stray_valid", int'(pick_valid), 0);
            chk("stray_busy", int'(busy), 0);
        end

        // Reset in WAIT aborts silently; the late mod_done is ignored.
        wait_idle("rstwait");
        resp_lat = 8;
        req      = 1'b1;
        deck_cnt = 7'd30;
        @(negedge clk);
        req = 1'b0;
        t   = 0;
        while (!mod_start && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("rstwait_start", int'(mod_start), 1);
        repeat (2) @(negedge clk);
        chk("rstwait_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstwait_busy0", int'(busy), 0);
        chk("rstwait_mod_a", int'(mod_a), 0);
        chk("rstwait_mod_b", int'(mod_b), 0);
        chk("rstwait_idx", int'(pick_idx), 0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cnt += int'(pick_valid) + int'(pick_err) + int'(busy);
        end
        chk("rstwait_silent", cnt, 0);

        // Peer-board reset reloads the seed.
        interboard_rst = 1'b1;
        @(negedge clk);
        interboard_rst = 1'b0;
        do_pick(7'd127, 0, 2, -1, -1, 1'b0, "ibrst");
        chk("ibrst_seed", int'(mod_a), 'h5A);

        // No response from the modulo unit.
        wait_idle("nodone");
        old_idx  = pick_idx;
        resp_en  = 1'b0;
        req      = 1'b1;
        deck_cnt = 7'd100;
        @(negedge clk);
        req = 1'b0;
        t   = 0;
        while (!mod_start && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("nodone_start", int'(mod_start), 1);
`ifdef RAND_TIMEOUT_EN
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k < 11) begin
                chk("tmo_early_err", int'(pick_err), 0);
                chk("tmo_busy", int'(busy), 1);
            end else begin
                chk("tmo_err", int'(pick_err), 1);
                chk("tmo_busy0", int'(busy), 0);
                chk("tmo_idx", int'(pick_idx), int'(old_idx));
                chk("tmo_valid", int'(pick_valid), 0);
            end
        end
`else
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cnt += int'(pick_err) + int'(pick_valid) + int'(!busy);
        end
        chk("wait_forever", cnt, 0);
        stray_req++;
        t = 0;
        while (!pick_valid && t < 6) begin
            @(negedge clk);
            t++;
        end
        chk("late_done_valid", int'(pick_valid), 1);
        chk("late_done_idx", int'(pick_idx), 'h55);
`endif
        resp_en = 1'b1;

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) rdeck = 7'd0;
            else rdeck = 7'($urandom_range(1, 127));
            do_pick(rdeck, int'($urandom_range(0, 3)),
                    int'($urandom_range(1, 5)), -1, -1,
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
